branch_flag_gen: RTL
====================

BRANCH_FLAG_GEN -- requirements
Module: branch_flag_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 16, the operand width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port id_valid, input, 1 bit: decode-stage instruction present.
REQ-005 SHALL have port id_brControl, input, 3 bits: branch code; bit2 = branch, [1:0] = 00 EQZ, 01 NEZ, 10 LTZ, 11 GEZ.
REQ-006 SHALL have port id_rs, input, 3 bits: index of the compared register.
REQ-007 SHALL have port rf_data, input, DATA_W bits: register-file read of id_rs.
REQ-008 SHALL have ports ex_wr_en (input, 1 bit), ex_is_load (input, 1 bit), ex_wr_reg (input, 3 bits) and ex_result (input, DATA_W bits): EX-stage writer.
REQ-009 SHALL have ports mem_wr_en (input, 1 bit), mem_wr_reg (input, 3 bits) and mem_result (input, DATA_W bits): MEM-stage writer.
REQ-010 SHALL have port flush, input, 1 bit: squash the in-flight decode instruction.
REQ-011 SHALL have port stall, output, 1 bit: hold the upstream IF/ID stage this cycle.
REQ-012 SHALL have port br_valid, output, 1 bit: registered branch outputs are valid.
REQ-013 SHALL have ports brControl_q (output, 3 bits), ZF (output, 1 bit) and SF (output, 1 bit): registered flags for the branch evaluator.
REQ-014 SHALL have port stall_cnt, output, 8 bits: saturating count of stall cycles.

Function
REQ-015 SHALL select the operand with priority EX writer > MEM writer > rf_data; a writer matches only when its wr_en is high and its wr_reg equals id_rs.
REQ-016 SHALL NOT use an EX match with ex_is_load=1 as a forwarding source.
REQ-017 SHALL compute ZF = (operand == 0) and SF = operand[DATA_W-1].
REQ-018 SHALL register ZF, SF and brControl_q, with 1-cycle latency, on an edge where id_valid=1, stall=0 and flush=0; br_valid SHALL equal id_brControl[2] at that edge.
REQ-019 SHALL set br_valid to 0 on every other edge, and SHALL hold ZF, SF and brControl_q unchanged on those edges.
REQ-020 SHALL implement a two-state FSM with states RUN and LDWAIT.
- In RUN, stall=1 (combinational) when id_valid and id_brControl[2] and ex_wr_en and ex_is_load and ex_wr_reg==id_rs; the FSM then moves to LDWAIT.
- In LDWAIT, stall=0, the MEM forward supplies the operand, outputs are captured, and the FSM moves to RUN.
REQ-021 SHALL make flush dominant: in any state flush forces next state RUN, br_valid=0 and stall=0.
REQ-022 SHALL never assert stall for a non-branch instruction (id_brControl[2]=0).
REQ-023 SHALL increment stall_cnt on each cycle with stall=1, saturating at 255 with no wrap.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force state=RUN, br_valid=0, ZF=0, SF=0, brControl_q=000 and stall_cnt=0.
REQ-025 SHALL abandon LDWAIT when reset occurs mid-stall, with no capture on release.

Configuration
REQ-026 SHALL honour macro BR_FWD_EN.
- Defined: forwarding per REQ-015 through REQ-020.
- Undefined: the operand is always rf_data; stall=1 whenever a branch's id_rs matches any enabled EX or MEM writer (load or not), and the FSM stays in RUN.

Structure
REQ-027 SHALL place the brControl encodings (BR_EQZ, BR_NEZ, BR_LTZ, BR_GEZ) and the FSM state typedef in the shared package br_pkg.
REQ-028 SHALL implement operand selection in one sub-module, br_fwd_mux, that is purely combinational.

Verification
REQ-029 SHALL cover: BEQZ (100) with rf_data=0 and no hazard -> next cycle br_valid=1, ZF=1, SF=0.
REQ-030 SHALL cover: BLTZ with EX ALU writer to id_rs, ex_result=16'h8000, rf_data=5 -> SF=1, ZF=0, stall=0.
REQ-031 SHALL cover: BNEZ behind a load to id_rs -> stall=1 for one cycle, FSM in LDWAIT; next cycle mem_result=0 -> ZF=1, br_valid=1, stall_cnt=1.
REQ-032 SHALL cover: flush asserted during LDWAIT -> br_valid=0 and state RUN on the next cycle.
REQ-033 SHALL cover: 300 forced load-use stalls -> stall_cnt=255.
REQ-034 SHALL cover: rst_n pulsed low mid-LDWAIT -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/br_pkg.sv
// -----------------------------------------------------------------------------
// br_pkg
// Shared definitions for the branch flag generator:
//   - brControl[1:0] condition encodings (BR_EQZ/BR_NEZ/BR_LTZ/BR_GEZ)
//   - position of the "is branch" bit inside brControl
//   - FSM state typedef (RUN / LDWAIT)
//   - saturating increment helper for the stall counter
// Optional feature macro used by the block: BR_FWD_EN
// -----------------------------------------------------------------------------
package br_pkg;

    localparam logic [1:0] BR_EQZ = 2'b00;
    localparam logic [1:0] BR_NEZ = 2'b01;
    localparam logic [1:0] BR_LTZ = 2'b10;
    localparam logic [1:0] BR_GEZ = 2'b11;

    // brControl[2] marks the instruction as a branch
    localparam int unsigned BR_BIT = 2;

    localparam logic [7:0] STALL_CNT_MAX = 8'd255;

    typedef enum logic {
        RUN    = 1'b0,
        LDWAIT = 1'b1
    } br_state_e;

    // Increment that sticks at STALL_CNT_MAX instead of wrapping
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == STALL_CNT_MAX) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/br_fwd_mux.sv
// -----------------------------------------------------------------------------
// br_fwd_mux
// Purely combinational operand selection for the branch compare, plus the
// hazard indication the top-level FSM uses to decide whether to stall.
// Macro BR_FWD_EN:
//   defined   - operand = EX (non-load) > MEM > register file;
//               hazard_o flags a load in EX writing id_rs (load-use).
//   undefined - operand = register file always;
//               hazard_o flags any enabled EX or MEM writer of id_rs.
// Ports:
//   id_rs_i                         compared register index
//   rf_data_i                       register-file read of id_rs_i
//   ex_wr_en_i/ex_is_load_i/
//   ex_wr_reg_i/ex_result_i         EX-stage writer
//   mem_wr_en_i/mem_wr_reg_i/
//   mem_result_i                    MEM-stage writer
//   operand_o                       selected operand
//   hazard_o                        operand not yet available this cycle
// -----------------------------------------------------------------------------
module br_fwd_mux
    import br_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [2:0]        id_rs_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic              ex_wr_en_i,
    input  logic              ex_is_load_i,
    input  logic [2:0]        ex_wr_reg_i,
    input  logic [DATA_W-1:0] ex_result_i,
    input  logic              mem_wr_en_i,
    input  logic [2:0]        mem_wr_reg_i,
    input  logic [DATA_W-1:0] mem_result_i,
    output logic [DATA_W-1:0] operand_o,
    output logic              hazard_o
);

    logic ex_hit_s;
    logic mem_hit_s;

    assign ex_hit_s  = ex_wr_en_i  && (ex_wr_reg_i  == id_rs_i);
    assign mem_hit_s = mem_wr_en_i && (mem_wr_reg_i == id_rs_i);

`ifdef BR_FWD_EN
    // Forwarding priority; a load in EX has no data yet so it never forwards
    always_comb begin
        operand_o = rf_data_i;
        hazard_o  = ex_hit_s && ex_is_load_i;
        if (ex_hit_s && !ex_is_load_i) begin
            operand_o = ex_result_i;
        end else if (mem_hit_s) begin
            operand_o = mem_result_i;
        end else begin
            operand_o = rf_data_i;
        end
    end
`else
    logic unused_s;
    assign unused_s = ^{ex_is_load_i, ex_result_i, mem_result_i};

    // No forwarding: any pending writer of id_rs means the RF value is stale
    always_comb begin
        operand_o = rf_data_i;
        hazard_o  = ex_hit_s || mem_hit_s;
    end
`endif

endmodule

// File: rtl/branch_flag_gen.sv
// -----------------------------------------------------------------------------
// branch_flag_gen
// Decode-stage branch flag generator. Picks the compared operand (with or
// without forwarding), derives ZF/SF, and registers them together with the
// branch code for the branch evaluator. A small RUN/LDWAIT FSM inserts one
// stall cycle for a load-use hazard when forwarding is enabled.
// Macro BR_FWD_EN: enables EX/MEM forwarding and the LDWAIT state; when
// undefined every hazard on id_rs stalls and the FSM stays in RUN.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   id_valid, id_brControl,
//   id_rs, rf_data              decode-stage instruction and its RF read
//   ex_* / mem_*                EX / MEM stage writers
//   flush                       squash the decode instruction (dominant)
//   stall                       combinational hold for IF/ID
//   br_valid, brControl_q,
//   ZF, SF                      registered branch outputs
//   stall_cnt                   saturating count of stall cycles
// -----------------------------------------------------------------------------
module branch_flag_gen
    import br_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [2:0]        id_brControl,
    input  logic [2:0]        id_rs,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              ex_wr_en,
    input  logic              ex_is_load,
    input  logic [2:0]        ex_wr_reg,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              mem_wr_en,
    input  logic [2:0]        mem_wr_reg,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              flush,
    output logic              stall,
    output logic              br_valid,
    output logic [2:0]        brControl_q,
    output logic              ZF,
    output logic              SF,
    output logic [7:0]        stall_cnt
);

    br_state_e         state_q, state_d;
    logic              br_valid_q, br_valid_d;
    logic [2:0]        brc_q, brc_d;
    logic              zf_q, zf_d;
    logic              sf_q, sf_d;
    logic [7:0]        cnt_q, cnt_d;

    logic [DATA_W-1:0] operand_s;
    logic              hazard_s;
    logic              req_s;
    logic              stall_s;
    logic              capture_s;

    br_fwd_mux #(.DATA_W(DATA_W)) u_fwd_mux (
        .id_rs_i      (id_rs),
        .rf_data_i    (rf_data),
        .ex_wr_en_i   (ex_wr_en),
        .ex_is_load_i (ex_is_load),
        .ex_wr_reg_i  (ex_wr_reg),
        .ex_result_i  (ex_result),
        .mem_wr_en_i  (mem_wr_en),
        .mem_wr_reg_i (mem_wr_reg),
        .mem_result_i (mem_result),
        .operand_o    (operand_s),
        .hazard_o     (hazard_s)
    );

    // Only branches can request a stall
    assign req_s = id_valid && id_brControl[BR_BIT] && hazard_s;

    // FSM next state and stall; flush overrides everything
    always_comb begin
        state_d = RUN;
        stall_s = 1'b0;
        case (state_q)
            RUN: begin
                stall_s = req_s;
`ifdef BR_FWD_EN
                state_d = req_s ? LDWAIT : RUN;
`else
                state_d = RUN;
`endif
            end
            LDWAIT: begin
                // Load data now sits in MEM and is forwarded from there
                stall_s = 1'b0;
                state_d = RUN;
            end
            default: begin
                stall_s = 1'b0;
                state_d = RUN;
            end
        endcase
        if (flush) begin
            stall_s = 1'b0;
            state_d = RUN;
        end else begin
            state_d = state_d;
        end
    end

    assign capture_s = id_valid && !stall_s && !flush;

    // Next values of the registered branch outputs and stall counter
    always_comb begin
        br_valid_d = 1'b0;
        brc_d      = brc_q;
        zf_d       = zf_q;
        sf_d       = sf_q;
        cnt_d      = cnt_q;
        if (capture_s) begin
            br_valid_d = id_brControl[BR_BIT];
            brc_d      = id_brControl;
            zf_d       = (operand_s == {DATA_W{1'b0}});
            sf_d       = operand_s[DATA_W-1];
        end else begin
            br_valid_d = 1'b0;
        end
        if (stall_s) begin
            cnt_d = sat_inc(cnt_q);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            br_valid_q <= 1'b0;
            brc_q      <= 3'b000;
            zf_q       <= 1'b0;
            sf_q       <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            br_valid_q <= br_valid_d;
            brc_q      <= brc_d;
            zf_q       <= zf_d;
            sf_q       <= sf_d;
            cnt_q      <= cnt_d;
        end
    end

    // Stall is quiet while reset is held so every output shows reset values
    assign stall       = stall_s && rst_n;
    assign br_valid    = br_valid_q;
    assign brControl_q = brc_q;
    assign ZF          = zf_q;
    assign SF          = sf_q;
    assign stall_cnt   = cnt_q;

endmodule
